// File: rtl/ccd_pattern_tx.sv
// Test-pattern camera transmitter: byte-serial YCbCr 4:2:2 with frame/line strobes.
// Optional macro CCD_TX_SCROLL_EN makes ramp and checker patterns scroll one pixel per frame.
module ccd_pattern_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 288,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iEND,
    input  logic [1:0]  iMODE,
    input  logic [23:0] iCOLOR,
    output logic [7:0]  oDATA,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [31:0] oFrame_Cont,
    output logic        oBUSY
);

    localparam logic [15:0] ACT_BYTES = 16'(2 * H_ACTIVE);
    localparam logic [15:0] LP_LAST   = 16'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [15:0] VS_LAST   = 16'(VSYNC_LINES - 1);
    localparam logic [15:0] VB_LAST   = 16'(V_BACK - 1);
    localparam logic [15:0] VA_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] VF_LAST   = 16'(V_FRONT - 1);
    localparam logic [15:0] BAR_W     = 16'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    state_t      state, state_n;
    logic [15:0] hcnt, hcnt_n;
    logic [15:0] vcnt, vcnt_n;
    logic [15:0] last_line;
    logic        stop;
    logic [1:0]  mode;
    logic [23:0] color;
    logic [7:0]  data;
    logic        fval, lval, busy;
    logic [31:0] frame_cnt;

    logic        fval_n, lval_n, busy_n;
    logic [7:0]  data_n;
    logic [15:0] pix;
    logic [7:0]  spix;
    logic [15:0] bar_raw;
    logic [2:0]  bar;
    logic [23:0] ycc;
    logic [7:0]  pix_byte;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hEB8080;
            3'd1:    return 24'hD21092;
            3'd2:    return 24'hAAA610;
            3'd3:    return 24'h913622;
            3'd4:    return 24'h6ACADE;
            3'd5:    return 24'h515AF0;
            3'd6:    return 24'h29F06E;
            default: return 24'h108080;
        endcase
    endfunction

    always_comb begin
        state_n   = state;
        hcnt_n    = hcnt;
        vcnt_n    = vcnt;
        last_line = '0;
        case (state)
            VSYNC:   last_line = VS_LAST;
            VBACK:   last_line = VB_LAST;
            ACTIVE:  last_line = VA_LAST;
            VFRONT:  last_line = VF_LAST;
            default: last_line = '0;
        endcase

        if (state == IDLE) begin
            if (iSTART && !iEND) begin
                state_n = VSYNC;
                hcnt_n  = '0;
                vcnt_n  = '0;
            end
        end else if (hcnt != LP_LAST) begin
            hcnt_n = hcnt + 16'd1;
        end else begin
            hcnt_n = '0;
            if (vcnt != last_line) begin
                vcnt_n = vcnt + 16'd1;
            end else begin
                vcnt_n = '0;
                case (state)
                    VSYNC:   state_n = VBACK;
                    VBACK:   state_n = ACTIVE;
                    ACTIVE:  state_n = VFRONT;
                    VFRONT:  state_n = (stop || iEND) ? IDLE : VSYNC;
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    // Outputs are derived from the next counters so the registered strobes and
    // data line up exactly with the state they describe.
    always_comb begin
        pix = hcnt_n[0] ? {1'b0, hcnt_n[15:1]} : {1'b0, hcnt_n[15:2], 1'b0};
`ifdef CCD_TX_SCROLL_EN
        spix = pix[7:0] + frame_cnt[7:0];
`else
        spix = pix[7:0];
`endif
        bar_raw = pix / BAR_W;
        bar     = (bar_raw > 16'd7) ? 3'd7 : bar_raw[2:0];

        case (mode)
            2'd0:    ycc = bar_color(bar);
            2'd1:    ycc = {spix, 8'h80, 8'h80};
            2'd2:    ycc = color;
            default: ycc = {((spix[5] ^ vcnt_n[5]) ? 8'hEB : 8'h10), 8'h80, 8'h80};
        endcase

        case (hcnt_n[1:0])
            2'd0:    pix_byte = ycc[15:8];
            2'd2:    pix_byte = ycc[7:0];
            default: pix_byte = ycc[23:16];
        endcase

        fval_n = (state_n == VSYNC);
        busy_n = (state_n != IDLE);
        lval_n = (state_n == ACTIVE) && (hcnt_n < ACT_BYTES);
        data_n = lval_n ? pix_byte : '0;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= IDLE;
            hcnt      <= '0;
            vcnt      <= '0;
            stop      <= 1'b0;
            mode      <= '0;
            color     <= '0;
            data      <= '0;
            fval      <= 1'b0;
            lval      <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_n;
            hcnt  <= hcnt_n;
            vcnt  <= vcnt_n;
            if (state_n == IDLE) begin
                stop <= 1'b0;
            end else if (iEND) begin
                stop <= 1'b1;
            end
            if (state_n == VSYNC && state != VSYNC) begin
                mode  <= iMODE;
                color <= iCOLOR;
            end
            data <= data_n;
            fval <= fval_n;
            lval <= lval_n;
            busy <= busy_n;
            if (fval && !fval_n) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

    assign oDATA       = data;
    assign oFVAL       = fval;
    assign oLVAL       = lval;
    assign oBUSY       = busy;
    assign oFrame_Cont = frame_cnt;

endmodule

// File: tb/tb_ccd_pattern_tx.sv
// Directed bench for ccd_pattern_tx with a 20-clock line and 7-line frame.
module tb_ccd_pattern_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop_req = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] color = '0;
    logic [7:0]  data;
    logic        fval, lval, busy;
    logic [31:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    ccd_pattern_tx #(
        .H_ACTIVE   (8),
        .H_BLANK    (4),
        .V_ACTIVE   (4),
        .VSYNC_LINES(1),
        .V_BACK     (1),
        .V_FRONT    (1)
    ) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iSTART     (start),
        .iEND       (stop_req),
        .iMODE      (mode),
        .iCOLOR     (color),
        .oDATA      (data),
        .oFVAL      (fval),
        .oLVAL      (lval),
        .oFrame_Cont(frame_cnt),
        .oBUSY      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Sample k is taken on the negedge after the k-th rising edge following start.
    // pat holds the 16 bytes of every active line, first byte in the top bits.
    task automatic frame_check(input logic [127:0] pat, input int fc0,
                               input int end_at, input int mode_at, input logic [1:0] new_mode,
                               input int start_at);
        for (int k = 0; k < 140; k++) begin
            logic       exp_lval;
            logic [7:0] exp_data;
            int         h;
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == end_at) stop_req = 1'b1;
            if (k == end_at + 1) stop_req = 1'b0;
            if (k == start_at) start = 1'b1;
            if (k == start_at + 1) start = 1'b0;
            if (k == mode_at) mode = new_mode;
            h        = (k - 40) % 20;
            exp_lval = (k >= 40) && (k < 120) && (h < 16);
            exp_data = exp_lval ? pat[8 * (15 - h) +: 8] : 8'h00;
            check("fval", 32'(fval), 32'(k < 20));
            check("lval", 32'(lval), 32'(exp_lval));
            check("data", 32'(data), 32'(exp_data));
            check("busy", 32'(busy), 32'd1);
            if (k == 19) check("fcnt_pre", frame_cnt, 32'(fc0));
            if (k == 20) check("fcnt_post", frame_cnt, 32'(fc0 + 1));
        end
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int highs = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (fval || busy || lval || data != 8'h00) highs++;
        end
        check(tag, 32'(highs), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'h0);
        check("rst_fval", 32'(fval), 32'h0);
        check("rst_lval", 32'(lval), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fcnt", frame_cnt, 32'h0);
        rst = 1'b0;
        idle_check("idle_no_start", 10);

        // Mode 2, then mode 3 and mode 0 frames back to back; mode changes mid-frame
        // only take effect at the next frame. iEND in frame C line 2, iSTART ignored.
        mode  = 2'd2;
        color = 24'h515AF0;
        start = 1'b1;
        frame_check(128'h5A51F051_5A51F051_5A51F051_5A51F051, 0, -10, 50, 2'd3, -10);
        frame_check(128'h80108010_80108010_80108010_80108010, 1, -10, 60, 2'd0, -10);
        frame_check(128'h80EB80D2_A6AA1091_CA6ADE51_F0296E10, 2, 85, -10, 2'd0, 86);
        @(negedge clk);
        check("end_busy_low", 32'(busy), 32'h0);
        check("end_fval_low", 32'(fval), 32'h0);
        check("end_fcnt", frame_cnt, 32'd3);
        idle_check("end_no_restart", 30);
        check("end_fcnt_hold", frame_cnt, 32'd3);

        // Reset in the middle of an active line.
        mode  = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (44) @(negedge clk);
        check("pre_rst_lval", 32'(lval), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_lval", 32'(lval), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_fcnt", frame_cnt, 32'h0);
        idle_check("post_rst_idle", 5);

        // iSTART and iEND together: no frame starts.
        start    = 1'b1;
        stop_req = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        stop_req = 1'b0;
        check("start_end_busy", 32'(busy), 32'h0);
        check("start_end_fval", 32'(fval), 32'h0);

        // Clean single luma-ramp frame after reset, stopped during its first line.
        start = 1'b1;
        frame_check(128'h80008001_80028003_80048005_80068007, 0, 41, -10, 2'd1, -10);
        @(negedge clk);
        check("ramp_busy_low", 32'(busy), 32'h0);
        check("ramp_fcnt", frame_cnt, 32'd1);
        idle_check("ramp_no_restart", 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
